// File: rtl/cpu_pkg.sv
// Shared core definitions: reset defaults, fetch state encoding and the
// branch offset shift used by the IF stage and the branch target adder.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
  localparam int          BR_SHIFT     = 2;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_stage_if.sv
// Instruction memory req/ack fetch bus between the IF stage (master) and
// the instruction memory (slave).
interface ifetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/branch_target.sv
// Branch target adder: br_pc4 + (sign_extend(br_imm16) << BR_SHIFT), mod 2^32.
module branch_target
  import cpu_pkg::*;
(
  input  logic [31:0] br_pc4,
  input  logic [15:0] br_imm16,
  output logic [31:0] target
);

  logic [31:0] offset_s;

  // word offset widened to a byte offset
  always_comb begin
    offset_s = {{(32 - 16 - BR_SHIFT){br_imm16[15]}}, br_imm16, {BR_SHIFT{1'b0}}};
    target   = br_pc4 + offset_s;
  end

endmodule

// File: rtl/ifetch_stage.sv
// Pipeline IF stage: owns the PC, fetches over a req/ack bus and drives the
// IF/ID register, honouring the ID stall and the EX-resolved taken branch.
module ifetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  br_taken,
  input  logic [15:0]           br_imm16,
  input  logic [31:0]           br_pc4,
  ifetch_stage_if.master        imem,
  output logic [31:0]           id_inst,
  output logic [31:0]           id_pc4,
  output logic                  id_valid,
  output logic [31:0]           fetch_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic [31:0]  buf_inst_q, buf_inst_d;
  logic [31:0]  buf_pc4_q, buf_pc4_d;
  logic [31:0]  id_inst_q, id_inst_d;
  logic [31:0]  id_pc4_q, id_pc4_d;
  logic         id_valid_q, id_valid_d;

  logic [31:0]  target_s;
  logic [31:0]  pc_plus4_s;
  logic         deliver_s;
  logic [31:0]  deliver_inst_s;
  logic [31:0]  deliver_pc4_s;

  branch_target u_branch_target (
    .br_pc4   (br_pc4),
    .br_imm16 (br_imm16),
    .target   (target_s)
  );

  assign pc_plus4_s = pc_q + 32'd4;

  // fetch sequencing: PC, hold buffer and wrong-path drop tracking
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    drop_addr_d    = drop_addr_q;
    buf_inst_d     = buf_inst_q;
    buf_pc4_d      = buf_pc4_q;
    deliver_s      = 1'b0;
    deliver_inst_s = buf_inst_q;
    deliver_pc4_s  = buf_pc4_q;
    case (state_q)
      S_REQ: begin
        if (imem.ack) begin
          if (br_taken) begin
            pc_d = target_s;
          end else if (stall) begin
            pc_d       = pc_plus4_s;
            buf_inst_d = imem.rdata;
            buf_pc4_d  = pc_plus4_s;
            state_d    = S_HOLD;
          end else begin
            pc_d           = pc_plus4_s;
            deliver_s      = 1'b1;
            deliver_inst_s = imem.rdata;
            deliver_pc4_s  = pc_plus4_s;
          end
        end else if (br_taken) begin
          // the bus address must stay put until the stale request is acked
          drop_addr_d = pc_q;
          pc_d        = target_s;
          state_d     = S_DROP;
        end else begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (br_taken) begin
          pc_d    = target_s;
          state_d = S_REQ;
        end else if (!stall) begin
          deliver_s = 1'b1;
          state_d   = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DROP: begin
        if (br_taken) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
        if (imem.ack) begin
          state_d = S_REQ;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // IF/ID register: squash beats stall beats delivery beats bubble
  always_comb begin
    id_inst_d  = id_inst_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;
    if (br_taken) begin
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else if (stall) begin
      id_valid_d = id_valid_q;
    end else if (deliver_s) begin
      id_inst_d  = deliver_inst_s;
      id_pc4_d   = deliver_pc4_s;
      id_valid_d = 1'b1;
    end else begin
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      drop_addr_q <= 32'h0000_0000;
      buf_inst_q  <= 32'h0000_0000;
      buf_pc4_q   <= 32'h0000_0000;
      id_inst_q   <= NOP_INST;
      id_pc4_q    <= 32'h0000_0000;
      id_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      buf_inst_q  <= buf_inst_d;
      buf_pc4_q   <= buf_pc4_d;
      id_inst_q   <= id_inst_d;
      id_pc4_q    <= id_pc4_d;
      id_valid_q  <= id_valid_d;
    end
  end

  assign imem.req  = !rst && (state_q != S_HOLD);
  assign imem.addr = (state_q == S_DROP) ? {drop_addr_q[31:2], 2'b00} : {pc_q[31:2], 2'b00};
  assign id_inst   = id_inst_q;
  assign id_pc4    = id_pc4_q;
  assign id_valid  = id_valid_q;
  assign fetch_pc  = pc_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: directed test-plan scenarios plus random stall,
// branch and wait-state traffic against a fetch-stream model.
module tb_ifetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_imm16 = 16'h0000;
  logic [31:0] br_pc4 = 32'h0000_0000;
  logic [31:0] id_inst, id_pc4, fetch_pc;
  logic        id_valid;
  logic [31:0] w_id_inst, w_id_pc4, w_fetch_pc;
  logic        w_id_valid;

  int tests = 0;
  int fails = 0;

  ifetch_stage_if mif ();
  ifetch_stage_if wif ();

  ifetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken),
    .br_imm16(br_imm16), .br_pc4(br_pc4), .imem(mif.master),
    .id_inst(id_inst), .id_pc4(id_pc4), .id_valid(id_valid), .fetch_pc(fetch_pc)
  );

  ifetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .br_taken(1'b0),
    .br_imm16(16'h0000), .br_pc4(32'h0000_0000), .imem(wif.master),
    .id_inst(w_id_inst), .id_pc4(w_id_pc4), .id_valid(w_id_valid), .fetch_pc(w_fetch_pc)
  );

  // memories return the address as the instruction word
  assign mif.rdata = mif.addr;
  assign wif.ack   = wif.req;
  assign wif.rdata = wif.addr;

  always #5 clk = ~clk;

  // model of the fetch stream
  logic [31:0] m_pc = RESET_PC_DEF;
  logic        m_hold = 1'b0;
  logic [31:0] m_buf_inst = 32'h0;
  logic [31:0] m_buf_pc4 = 32'h0;
  logic        m_drop = 1'b0;
  logic [31:0] m_drop_addr = 32'h0;
  logic [31:0] m_id_inst = NOP_INST_DEF;
  logic [31:0] m_id_pc4 = 32'h0;
  logic        m_id_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // one clock cycle: drive, compare against the model, choose ack, advance the model
  task automatic step(input logic r, input logic s, input logic b,
                      input logic [31:0] p4, input logic [15:0] imm, input int ack_mode);
    logic        exp_req, a, got_word;
    logic [31:0] exp_addr, tgt, word_inst, word_pc4;
    @(negedge clk);
    rst = r; stall = s; br_taken = b; br_pc4 = p4; br_imm16 = imm;
    #1;
    exp_req  = !r && !m_hold;
    exp_addr = m_drop ? m_drop_addr : m_pc;
    chk("imem_req", {31'd0, mif.req}, {31'd0, exp_req});
    if (exp_req) begin
      chk("imem_addr", mif.addr, exp_addr);
      chk("addr_align", {30'd0, mif.addr[1:0]}, 32'd0);
    end
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_id_valid});
    chk("id_inst", id_inst, m_id_inst);
    if (m_id_valid) begin
      chk("id_pc4", id_pc4, m_id_pc4);
      chk("inst_matches_pc4", id_inst, id_pc4 - 32'd4);
    end
    chk("fetch_pc", fetch_pc, m_pc);

    case (ack_mode)
      0: a = 1'b0;
      1: a = mif.req;
      2: a = mif.req & ($urandom_range(0, 2) != 0);
      default: a = 1'b1;
    endcase
    mif.ack = a;

    tgt = p4 + ({{16{imm[15]}}, imm} * 32'd4);
    got_word = 1'b0;
    word_inst = 32'h0;
    word_pc4 = 32'h0;
    if (r) begin
      m_pc = RESET_PC_DEF; m_hold = 1'b0; m_drop = 1'b0;
      m_id_inst = NOP_INST_DEF; m_id_pc4 = 32'h0; m_id_valid = 1'b0;
    end else begin
      if (m_hold) begin
        if (b) begin
          m_hold = 1'b0; m_pc = tgt;
        end else if (!s) begin
          m_hold = 1'b0; got_word = 1'b1; word_inst = m_buf_inst; word_pc4 = m_buf_pc4;
        end
      end else if (m_drop) begin
        if (b) m_pc = tgt;
        if (a) m_drop = 1'b0;
      end else if (a) begin
        if (b) begin
          m_pc = tgt;
        end else begin
          if (s) begin
            m_hold = 1'b1; m_buf_inst = exp_addr; m_buf_pc4 = m_pc + 32'd4;
          end else begin
            got_word = 1'b1; word_inst = exp_addr; word_pc4 = m_pc + 32'd4;
          end
          m_pc = m_pc + 32'd4;
        end
      end else if (b) begin
        m_drop = 1'b1; m_drop_addr = m_pc; m_pc = tgt;
      end
      if (b) begin
        m_id_valid = 1'b0; m_id_inst = NOP_INST_DEF;
      end else if (s) begin
        m_id_valid = m_id_valid;
      end else if (got_word) begin
        m_id_valid = 1'b1; m_id_inst = word_inst; m_id_pc4 = word_pc4;
      end else begin
        m_id_valid = 1'b0; m_id_inst = NOP_INST_DEF;
      end
    end
  endtask

  initial begin
    mif.ack = 1'b0;

    // reset, then zero-wait streaming
    step(1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 0);
    chk("rst_req_low", {31'd0, mif.req}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1);
    chk("first_addr", mif.addr, 32'h0040_0000);
    chk("first_valid", {31'd0, id_valid}, 32'd0);
    chk("wrap_addr0", wif.addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1);
    chk("stream_pc4_0", id_pc4, 32'h0040_0004);
    chk("stream_fetch_pc_0", fetch_pc, 32'h0040_0004);
    chk("wrap_addr1", wif.addr, 32'h0000_0000);
    chk("wrap_pc4", w_id_pc4, 32'h0000_0000);
    chk("wrap_valid", {31'd0, w_id_valid}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1);
    chk("stream_pc4_1", id_pc4, 32'h0040_0008);
    chk("stream_fetch_pc_1", fetch_pc, 32'h0040_0008);
    step(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1);
    chk("stream_pc4_2", id_pc4, 32'h0040_000C);
    chk("stream_valid_2", {31'd0, id_valid}, 32'd1);

    // stall for 3 cycles with ack available
    step(1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 16'h0, 1);
      chk("stall_hold_pc4", id_pc4, 32'h0040_0004);
      if (i > 0) chk("stall_req_low", {31'd0, mif.req}, 32'd0);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1);
    chk("after_stall_pc4", id_pc4, 32'h0040_0008);

    // taken branch backwards squashes the fetched slot
    step(1'b0, 1'b0, 1'b1, 32'h0040_0010, 16'hFFFC, 1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1);
    chk("br_addr", mif.addr, 32'h0040_0000);
    chk("br_squash", {31'd0, id_valid}, 32'd0);

    // 3-cycle wait with a branch during the wait
    step(1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 0);
    step(1'b0, 1'b0, 1'b1, 32'h0040_0008, 16'h0004, 0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 0);
    chk("drop_addr_held", mif.addr, 32'h0040_0000);
    step(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1);
    chk("drop_addr_at_ack", mif.addr, 32'h0040_0000);
    step(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 0);
    chk("redirect_addr", mif.addr, 32'h0040_0018);
    chk("drop_discarded", {31'd0, id_valid}, 32'd0);

    // reset during a pending request, ack offered on the reset cycle
    step(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 3);
    chk("midrst_req", {31'd0, mif.req}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 0);
    chk("midrst_addr", mif.addr, 32'h0040_0000);
    chk("midrst_valid", {31'd0, id_valid}, 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, s, b;
      logic [31:0] p4;
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 7) == 0);
      p4 = $urandom() & 32'hFFFF_FFFC;
      step(r, s, b, p4, 16'($urandom()), 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
